// File: rtl/cpu_pkg.sv
// Shared CPU control definitions: sequencer states, opcode class
// constants and instruction-register field positions.
package cpu_pkg;

  typedef enum logic [3:0] {
    S_RST  = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_T5   = 4'd6,
    S_T6   = 4'd7,
    S_HALT = 4'd8
  } state_t;

  // Opcode classes; anything not listed decodes as NOP.
  localparam logic [4:0] OP_ALU_LO = 5'b00011;
  localparam logic [4:0] OP_ALU_HI = 5'b01100;
  localparam logic [4:0] OP_MUL    = 5'b01111;
  localparam logic [4:0] OP_DIV    = 5'b10000;
  localparam logic [4:0] OP_HALT   = 5'b11011;

  // IR field bit positions.
  localparam int OPC_MSB = 31;
  localparam int OPC_LSB = 27;
  localparam int RA_MSB  = 26;
  localparam int RA_LSB  = 23;
  localparam int RB_MSB  = 22;
  localparam int RB_LSB  = 19;
  localparam int RC_MSB  = 18;
  localparam int RC_LSB  = 15;

  function automatic logic is_alu(input logic [4:0] op);
    return (op >= OP_ALU_LO) && (op <= OP_ALU_HI);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/cu_reg_select.sv
// Register-select decoder: 4-bit register field plus enable to a
// one-hot R0..R15 strobe. R0 decodes like any other register.
module cu_reg_select
  import cpu_pkg::*;
(
  input  logic [3:0]  sel,
  input  logic        en,
  output logic [15:0] onehot
);

  // One bit set only when enabled; all-zero otherwise.
  always_comb begin
    onehot = '0;
    if (en) onehot[sel] = 1'b1;
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired control sequencer: fetch (T0..T2), decode/execute (T3..T6),
// HALT. Moore decode of registered state plus ir.
// Optional build macro CU_MEMWAIT_EN: T1 stretches until mem_rdy is high.
module control_sequencer
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] ir,
  input  logic        mem_rdy,
  output logic        PCout,
  output logic        PCin,
  output logic        pcInc,
  output logic        MARin,
  output logic        MDR_read,
  output logic        MDR_enable,
  output logic        MDRout,
  output logic        IR_enable,
  output logic        Y_enable,
  output logic        Zlow_enable,
  output logic        Zhigh_enable,
  output logic        Zlowout,
  output logic        Zhighout,
  output logic        HI_enable,
  output logic        LO_enable,
  output logic        run,
  output logic [15:0] r_in,
  output logic [15:0] r_out,
  output logic [4:0]  op_code
);

  state_t      state, nxt;
  logic [4:0]  opc;
  logic [3:0]  ra, rb, rc;
  logic        alu, md;
  logic        rin_en, rout_en;
  logic [3:0]  rout_sel;
  logic [14:0] unused_ir;

  assign opc = ir[OPC_MSB:OPC_LSB];
  assign ra  = ir[RA_MSB:RA_LSB];
  assign rb  = ir[RB_MSB:RB_LSB];
  assign rc  = ir[RC_MSB:RC_LSB];
  assign alu = is_alu(opc);
  assign md  = is_muldiv(opc);
  assign unused_ir = ir[14:0];

`ifndef CU_MEMWAIT_EN
  logic unused_mem_rdy;
  assign unused_mem_rdy = mem_rdy;
`endif

  // State register; reset forces RST immediately, aborting any instruction.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_RST;
    else          state <= nxt;
  end

  // Next-state sequencing.
  always_comb begin
    nxt = state;
    unique case (state)
      S_RST: nxt = S_T0;
      S_T0:  nxt = S_T1;
`ifdef CU_MEMWAIT_EN
      S_T1:  nxt = mem_rdy ? S_T2 : S_T1;
`else
      S_T1:  nxt = S_T2;
`endif
      S_T2:  nxt = S_T3;
      S_T3: begin
        if (alu || md)           nxt = S_T4;
        else if (opc == OP_HALT) nxt = S_HALT;
        else                     nxt = S_T0;
      end
      S_T4:   nxt = S_T5;
      S_T5:   nxt = md ? S_T6 : S_T0;
      S_T6:   nxt = S_T0;
      S_HALT: nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  // Register bus drive: Rb in T3, Rc in T4; write-back to Ra in T5 (ALU only).
  assign rout_en  = ((state == S_T3) || (state == S_T4)) && (alu || md);
  assign rout_sel = (state == S_T4) ? rc : rb;
  assign rin_en   = (state == S_T5) && alu;

  cu_reg_select u_rin  (.sel(ra),       .en(rin_en),  .onehot(r_in));
  cu_reg_select u_rout (.sel(rout_sel), .en(rout_en), .onehot(r_out));

  // Control strobes decoded from state (and ir in the execute steps).
  always_comb begin
    PCout        = 1'b0;
    PCin         = 1'b0;
    pcInc        = 1'b0;
    MARin        = 1'b0;
    MDR_read     = 1'b0;
    MDR_enable   = 1'b0;
    MDRout       = 1'b0;
    IR_enable    = 1'b0;
    Y_enable     = 1'b0;
    Zlow_enable  = 1'b0;
    Zhigh_enable = 1'b0;
    Zlowout      = 1'b0;
    Zhighout     = 1'b0;
    HI_enable    = 1'b0;
    LO_enable    = 1'b0;
    run          = 1'b0;
    op_code      = 5'b00000;
    unique case (state)
      S_T0: begin
        run = 1'b1; PCout = 1'b1; MARin = 1'b1; pcInc = 1'b1; Zlow_enable = 1'b1;
      end
      S_T1: begin
        run = 1'b1; MDR_read = 1'b1;
`ifdef CU_MEMWAIT_EN
        // Hold the read; latch data and update PC only once memory answers.
        MDR_enable = mem_rdy; Zlowout = mem_rdy; PCin = mem_rdy;
`else
        MDR_enable = 1'b1; Zlowout = 1'b1; PCin = 1'b1;
`endif
      end
      S_T2: begin
        run = 1'b1; MDRout = 1'b1; IR_enable = 1'b1;
      end
      S_T3: begin
        run = 1'b1;
        Y_enable = alu || md;
      end
      S_T4: begin
        run = 1'b1; op_code = opc; Zlow_enable = 1'b1; Zhigh_enable = md;
      end
      S_T5: begin
        run = 1'b1; Zlowout = 1'b1; LO_enable = md;
      end
      S_T6: begin
        run = 1'b1; Zhighout = 1'b1; HI_enable = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: doc/control_sequencer.md
CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 SHALL provide: clk  in  1  system clock; all state changes on rising edge.
REQ-002 SHALL provide: reset_n  in  1  asynchronous active-low reset.
REQ-003 SHALL provide: ir  in  32  instruction register contents; opcode ir[31:27], Ra ir[26:23], Rb ir[22:19], Rc ir[18:15].
REQ-004 SHALL provide: mem_rdy  in  1  memory read data valid (used only under CU_MEMWAIT_EN).
REQ-005 SHALL provide outputs, 1 bit each: PCout, PCin, pcInc, MARin, MDR_read, MDR_enable, MDRout, IR_enable, Y_enable, Zlow_enable, Zhigh_enable, Zlowout, Zhighout, HI_enable, LO_enable, run.
REQ-006 SHALL provide: r_in  out  16  one-hot register write enable R0..R15; r_out  out  16  one-hot register bus drive R0..R15.
REQ-007 SHALL provide: op_code  out  5  ALU operation select to the datapath.

Function
REQ-008 SHALL be a Moore FSM; all outputs decoded from the registered state plus ir only.
REQ-009 States: RST, T0, T1, T2, T3, T4, T5, T6, HALT.
REQ-010 RST -> T0 on the first rising edge after reset_n deasserts; run=1 in T0..T6.
REQ-011 T0: PCout, MARin, pcInc, Zlow_enable = 1.
REQ-012 T1: Zlowout, PCin, MDR_read, MDR_enable = 1.
REQ-013 T2: MDRout, IR_enable = 1; ir is valid from T3 onward.
REQ-014 Opcode classes: ALU = 5'b00011..5'b01100; MUL = 5'b01111; DIV = 5'b10000; HALT = 5'b11011; all others are NOP.
REQ-015 T3: r_out = onehot(Rb), Y_enable = 1 (ALU/MUL/DIV); NOP goes T3 -> T0 with no outputs asserted; HALT goes T3 -> HALT.
REQ-016 T4: r_out = onehot(Rc), op_code = ir[31:27], Zlow_enable = 1; MUL/DIV also assert Zhigh_enable.
REQ-017 T5 (ALU): Zlowout = 1, r_in = onehot(Ra); next state T0.
REQ-018 T5 (MUL/DIV): Zlowout, LO_enable = 1; T6: Zhighout, HI_enable = 1; next state T0.
REQ-019 op_code SHALL be 5'b00000 in every state except T4.
REQ-020 r_in and r_out SHALL be zero outside the states in REQ-015..REQ-018; never more than one bit set.
REQ-021 Latency: ALU 6 cycles (T0..T5), MUL/DIV 7 cycles, NOP 4 cycles, HALT 4 cycles, then stays in HALT.
REQ-022 HALT: all outputs 0, run = 0; exit only by reset_n.
REQ-023 R0 SHALL be addressable like any other register (no hardwired zero).

Reset
REQ-024 reset_n low SHALL force state RST immediately, independent of clk; all outputs 0, run = 0.
REQ-025 Reset asserted mid-instruction (any of T0..T6) SHALL abort it with no further enables; restart at T0.

Configuration
REQ-026 CU_MEMWAIT_EN defined: T1 holds while mem_rdy = 0 with MDR_read = 1 and MDR_enable = 0; MDR_enable, Zlowout and PCin assert only in the cycle mem_rdy = 1, then go to T2.
REQ-027 CU_MEMWAIT_EN undefined: T1 always lasts one cycle; mem_rdy ignored.

Structure
REQ-028 Shared package cpu_pkg SHALL hold the state enum, opcode class constants, and IR field bit positions.
REQ-029 Sub-module cu_reg_select SHALL decode the 4-bit field plus an enable into the 16-bit one-hot r_in/r_out.

Verification
REQ-030 Reset, then ir = 32'h489A8000 (shl r1,r3,r5), with R3 = 0x12 and R5 = 0x14 in the datapath -> T3 r_out = 16'h0008; T4 r_out = 16'h0020, op_code = 5'b01001; T5 r_in = 16'h0002; R1 = 0x01200000.
REQ-031 MUL opcode 01111, Rb = r2, Rc = r4 -> T4 asserts Zlow_enable and Zhigh_enable; T5 LO_enable; T6 HI_enable; back to T0 at cycle 8.
REQ-032 Opcode 11011 -> HALT after T3, run = 0, all outputs 0 for 20+ cycles; reset_n low then high -> T0.
REQ-033 Opcode 11111 (NOP) -> T3 with no enables asserted, next T0; r_in = 0 for the whole instruction.
REQ-034 reset_n pulsed low asynchronously mid-T4 -> op_code and enables drop to 0 before the next edge; no r_in pulse occurs.
REQ-035 CU_MEMWAIT_EN build, mem_rdy low for 3 cycles in T1 -> T1 lasts 4 cycles; MDR_enable asserts only in the 4th.
